// File: rtl/fpmul_arbiter.sv
// Round-robin sharing of one FP32 multiplier among N_REQ requesters; one operation in flight.
// Optional WAIT watchdog under `FPMUL_ARB_TIMEOUT_EN` (quiet-NaN response plus sticky timeout_err_o).
module fpmul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [32*N_REQ-1:0]  req_op1_i,
  input  logic [32*N_REQ-1:0]  req_op2_i,
  output logic [N_REQ-1:0]     req_ack_o,
  output logic [N_REQ-1:0]     rsp_valid_o,
  output logic [31:0]          rsp_res_o,
  output logic                 mul_ready_o,
  output logic [31:0]          mul_op1_o,
  output logic [31:0]          mul_op2_o,
  input  logic [31:0]          mul_res_i,
  input  logic                 mul_done_i,
  output logic                 busy_o
`ifdef FPMUL_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_err_o
`endif
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_param_chk
    $error("fpmul_arbiter: N_REQ must be 2..8 and TIMEOUT at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic [N_REQ-1:0]  req_ack_q, req_ack_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_res_q, rsp_res_d;
  logic              mul_ready_q, mul_ready_d;
  logic [31:0]       mul_op1_q, mul_op1_d;
  logic [31:0]       mul_op2_q, mul_op2_d;
  logic              busy_q, busy_d;

  logic              win_vld;
  logic [IDXW-1:0]   win_idx;
  logic [IDXW-1:0]   win_cand;
  logic [31:0]       op1_arr [N_REQ];
  logic [31:0]       op2_arr [N_REQ];

`ifdef FPMUL_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT);
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              terr_q, terr_d;
`endif

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op1_arr[g] = req_op1_i[32*g +: 32];
    assign op2_arr[g] = req_op2_i[32*g +: 32];
  end

  // Scan from farthest to nearest so the first set bit after last_q wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = last_q;
    win_cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      win_cand = IDXW'((int'(last_q) + k) % N_REQ);
      if (req_valid_i[win_cand]) begin
        win_vld = 1'b1;
        win_idx = win_cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    req_ack_d   = '0;
    rsp_valid_d = '0;
    rsp_res_d   = rsp_res_q;
    mul_ready_d = 1'b0;
    mul_op1_d   = mul_op1_q;
    mul_op2_d   = mul_op2_q;
    busy_d      = busy_q;
`ifdef FPMUL_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    terr_d      = terr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d            = S_ISSUE;
          idx_d              = win_idx;
          last_d             = win_idx;
          req_ack_d[win_idx] = 1'b1;
          mul_op1_d          = op1_arr[win_idx];
          mul_op2_d          = op2_arr[win_idx];
          mul_ready_d        = 1'b1;
          busy_d             = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FPMUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // A done arriving together with the timeout still completes normally.
        if (mul_done_i) begin
          rsp_res_d          = mul_res_i;
          rsp_valid_d[idx_q] = 1'b1;
          state_d            = S_IDLE;
          busy_d             = 1'b0;
        end
`ifdef FPMUL_ARB_TIMEOUT_EN
        else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          rsp_res_d          = 32'h7FC0_0000;
          rsp_valid_d[idx_q] = 1'b1;
          terr_d             = 1'b1;
          state_d            = S_IDLE;
          busy_d             = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= IDXW'(N_REQ - 1);
      req_ack_q   <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      mul_ready_q <= 1'b0;
      mul_op1_q   <= '0;
      mul_op2_q   <= '0;
      busy_q      <= 1'b0;
`ifdef FPMUL_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      terr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      req_ack_q   <= req_ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      mul_ready_q <= mul_ready_d;
      mul_op1_q   <= mul_op1_d;
      mul_op2_q   <= mul_op2_d;
      busy_q      <= busy_d;
`ifdef FPMUL_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      terr_q      <= terr_d;
`endif
    end
  end

  assign req_ack_o   = req_ack_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_res_o   = rsp_res_q;
  assign mul_ready_o = mul_ready_q;
  assign mul_op1_o   = mul_op1_q;
  assign mul_op2_o   = mul_op2_q;
  assign busy_o      = busy_q;
`ifdef FPMUL_ARB_TIMEOUT_EN
  assign timeout_err_o = terr_q;
`endif

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Scoreboard bench for fpmul_arbiter: grants and responses are queued by stimulus and checked by a monitor.
module tb_fpmul_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_op1, req_op2;
  logic [N-1:0]    req_ack, rsp_valid;
  logic [31:0]     rsp_res, mul_op1, mul_op2, mul_res;
  logic            mul_ready, mul_done, busy;
`ifdef FPMUL_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  logic            model_done, spur_done, model_en;
  logic [31:0]     model_res, spur_res;
  int              model_dly;

  assign mul_done = model_done | spur_done;
  assign mul_res  = model_res | spur_res;

  always #5 clk = ~clk;

  fpmul_arbiter #(.N_REQ(N), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_op1_i(req_op1), .req_op2_i(req_op2),
    .req_ack_o(req_ack), .rsp_valid_o(rsp_valid), .rsp_res_o(rsp_res),
    .mul_ready_o(mul_ready), .mul_op1_o(mul_op1), .mul_op2_o(mul_op2),
    .mul_res_i(mul_res), .mul_done_i(mul_done), .busy_o(busy)
`ifdef FPMUL_ARB_TIMEOUT_EN
    , .timeout_err_o(timeout_err)
`endif
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] op1_t [N];
  logic [31:0] op2_t [N];
  int          exp_gnt [$];
  int          exp_rsp_idx [$];
  logic [31:0] exp_rsp_res [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Hand-computed products for every operand pair the bench issues.
  function automatic logic [31:0] lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h4000_0000, 32'h4020_0000}: return 32'h40A0_0000; // 2.0 * 2.5
      {32'h4158_0000, 32'h3F80_0000}: return 32'h4158_0000; // 13.5 * 1.0
      {32'h4040_0000, 32'h3F00_0000}: return 32'h3FC0_0000; // 3.0 * 0.5
      {32'hC000_0000, 32'h4080_0000}: return 32'hC100_0000; // -2.0 * 4.0
      {32'h7F80_0000, 32'h0000_0000}: return 32'hFFC0_0000; // inf * 0
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      req_op1[32*i +: 32] = op1_t[i];
      req_op2[32*i +: 32] = op2_t[i];
    end
  endtask

  task automatic expect_txn(input int idx, input logic [31:0] res);
    exp_gnt.push_back(idx);
    exp_rsp_idx.push_back(idx);
    exp_rsp_res.push_back(res);
  endtask

  task automatic wait_ack();
    int t = 0;
    do begin @(negedge clk); t++; end while (req_ack == '0 && t < 100);
    if (req_ack == '0) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 300);
    if (rsp_valid == '0) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end
    while ((busy || exp_rsp_idx.size() != 0) && t < 500);
    if (busy || exp_rsp_idx.size() != 0) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // Multiplier model: done pulse model_dly cycles after the start pulse.
  initial begin
    logic [31:0] c1, c2;
    model_done = 1'b0;
    model_res  = '0;
    forever begin
      @(negedge clk);
      if (!rst && mul_ready && model_en) begin
        c1 = mul_op1;
        c2 = mul_op2;
        repeat (model_dly) @(negedge clk);
        chk("op1_stable", mul_op1, c1);
        chk("op2_stable", mul_op2, c2);
        model_res  = lut(c1, c2);
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
        model_res  = '0;
      end
    end
  end

  // Monitor: every grant and response must match the head of its queue.
  initial begin
    int g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_ack != '0) begin
          if (exp_gnt.size() == 0) chk("ack_unexpected", 32'(req_ack), 32'd0);
          else begin
            g = exp_gnt.pop_front();
            chk("ack_onehot", 32'(req_ack), 32'(1 << g));
            chk("ack_mul_ready", 32'(mul_ready), 32'd1);
            chk("ack_busy", 32'(busy), 32'd1);
            chk("ack_op1", mul_op1, op1_t[g]);
            chk("ack_op2", mul_op2, op2_t[g]);
          end
        end
        if (rsp_valid != '0) begin
          if (exp_rsp_idx.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
          else begin
            g = exp_rsp_idx.pop_front();
            chk("rsp_onehot", 32'(rsp_valid), 32'(1 << g));
            chk("rsp_res", rsp_res, exp_rsp_res.pop_front());
            chk("rsp_busy", 32'(busy), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = '0; spur_done = 1'b0; spur_res = '0;
    model_en = 1'b1; model_dly = 5;
    op1_t[0] = 32'h4000_0000; op2_t[0] = 32'h4020_0000;
    op1_t[1] = 32'h4158_0000; op2_t[1] = 32'h3F80_0000;
    op1_t[2] = 32'h4040_0000; op2_t[2] = 32'h3F00_0000;
    op1_t[3] = 32'hC000_0000; op2_t[3] = 32'h4080_0000;
    load_ops();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_res", rsp_res, 32'd0);
    chk("rst_mul_ready", 32'(mul_ready), 32'd0);
    chk("rst_mul_op1", mul_op1, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef FPMUL_ARB_TIMEOUT_EN
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif

    // Single request: 2.0 * 2.5, done 5 cycles after the start pulse.
    expect_txn(0, 32'h40A0_0000);
    req_valid = 4'b0001;
    wait_ack();
    req_valid = '0;
    wait_rsp(n);
    chk("single_latency", 32'(n), 32'd6);
    wait_idle();

    // Spurious done while idle.
    spur_done = 1'b1; spur_res = 32'h1111_1111;
    @(negedge clk);
    spur_done = 1'b0; spur_res = '0;
    repeat (3) begin
      @(negedge clk);
      chk("spur_busy", 32'(busy), 32'd0);
      chk("spur_rsp_valid", 32'(rsp_valid), 32'd0);
    end

    // Reset during WAIT: request dropped, late done ignored.
    model_en = 1'b0;
    exp_gnt.push_back(2);
    req_valid = 4'b0100;
    wait_ack();
    req_valid = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_res", rsp_res, 32'd0);
    chk("midrst_mul_op1", mul_op1, 32'd0);
    chk("midrst_mul_op2", mul_op2, 32'd0);
    chk("midrst_mul_ready", 32'(mul_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    spur_done = 1'b1; spur_res = 32'h1234_5678;
    @(negedge clk);
    spur_done = 1'b0; spur_res = '0;
    repeat (3) begin
      @(negedge clk);
      chk("late_done_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("late_done_busy", 32'(busy), 32'd0);
    end

    // Round-robin with all four requesting continuously.
    model_en = 1'b1; model_dly = 3;
    expect_txn(0, 32'h40A0_0000);
    expect_txn(1, 32'h4158_0000);
    expect_txn(2, 32'h3FC0_0000);
    expect_txn(3, 32'hC100_0000);
    expect_txn(0, 32'h40A0_0000);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) wait_ack();
    req_valid = '0;
    wait_idle();

    // Special values pass through unchanged.
    op1_t[1] = 32'h7F80_0000; op2_t[1] = 32'h0000_0000;
    load_ops();
    expect_txn(1, 32'hFFC0_0000);
    req_valid = 4'b0010;
    wait_ack();
    req_valid = '0;
    wait_idle();

    // Multiplier never answers.
    model_en = 1'b0;
`ifdef FPMUL_ARB_TIMEOUT_EN
    expect_txn(3, 32'h7FC0_0000);
    req_valid = 4'b1000;
    wait_ack();
    req_valid = '0;
    wait_rsp(n);
    chk("timeout_latency", 32'(n), 32'd65);
    @(negedge clk);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
`else
    exp_gnt.push_back(3);
    req_valid = 4'b1000;
    wait_ack();
    req_valid = '0;
    repeat (150) @(negedge clk);
    chk("no_timeout_busy", 32'(busy), 32'd1);
    exp_rsp_idx.push_back(3);
    exp_rsp_res.push_back(32'h3F80_0000);
    spur_done = 1'b1; spur_res = 32'h3F80_0000;
    @(negedge clk);
    spur_done = 1'b0; spur_res = '0;
`endif
    wait_idle();

    chk("queues_empty", 32'(exp_gnt.size() + exp_rsp_idx.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
